// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU load/store stage and the memory data port.
// Ports: clk, reset (async, active-high); cpu_rd_en/cpu_wr_en/cpu_addr/cpu_wr_data in,
//        cpu_rd_data/cpu_stall out; flush in; empty/full out;
//        mem_addr/mem_wr_data/mem_wr_en out, mem_rd_data in.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    output logic [31:0] cpu_rd_data,
    output logic        cpu_stall,
    input  logic        flush,
    output logic        empty,
    output logic        full,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rd_data
);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             drain_sel;
    logic             push;
    logic             pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));

    // The buffer owns the memory port unless a load is waiting and
    // nothing forces the drain (full, flush, or a store this cycle).
    assign drain_sel = !empty && (full || flush || !cpu_rd_en || cpu_wr_en);

    assign push = cpu_wr_en && !full;
    assign pop  = drain_sel;

    assign mem_wr_en   = drain_sel;
    assign mem_wr_data = data_q[head_q];
    assign mem_addr    = drain_sel ? {addr_q[head_q], 2'b00}
                                   : {cpu_addr[31:2], 2'b00};

    assign cpu_stall = (cpu_wr_en && full)
                     || (cpu_rd_en && !cpu_wr_en && drain_sel);

    // Walk from oldest to youngest so the last match wins.
    always_comb begin : fwd
        logic [PTR_W-1:0] idx;
        idx         = head_q;
        cpu_rd_data = mem_rd_data;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) &&
                (addr_q[idx] == cpu_addr[31:2])) begin
                cpu_rd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload is only meaningful while counted, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= cpu_addr[31:2];
            data_q[tail_q] <= cpu_wr_data;
        end
    end

endmodule
